// File: rtl/dsa_bilinear_interp_simd.sv
// Three-stage SIMD bilinear interpolator: horizontal blend, vertical blend, round.
// Global stall on output backpressure; drops and flags pulses arriving while stalled.
module dsa_bilinear_interp_simd #(
    parameter int SIMD_WIDTH = 4,
    parameter int FRAC_BITS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  p00 [0:SIMD_WIDTH-1],
    input  logic [7:0]  p01 [0:SIMD_WIDTH-1],
    input  logic [7:0]  p10 [0:SIMD_WIDTH-1],
    input  logic [7:0]  p11 [0:SIMD_WIDTH-1],
    input  logic [15:0] a   [0:SIMD_WIDTH-1],
    input  logic [15:0] b   [0:SIMD_WIDTH-1],
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_pixel [0:SIMD_WIDTH-1],
    output logic [15:0] vec_count,
    output logic        overflow,
    input  logic        clr_overflow,
    output logic        busy
);

    localparam int HW  = 8 + FRAC_BITS;
    localparam int VW  = 8 + 2 * FRAC_BITS;
    localparam int SH  = 2 * FRAC_BITS;
    localparam logic [FRAC_BITS:0] ONE = (FRAC_BITS+1)'(1) << FRAC_BITS;
    localparam logic [VW:0]        RND = (VW+1)'(1) << (SH - 1);

    logic adv;

    logic                 s1_valid;
    logic [HW-1:0]        s1_top [0:SIMD_WIDTH-1];
    logic [HW-1:0]        s1_bot [0:SIMD_WIDTH-1];
    logic [FRAC_BITS-1:0] s1_b   [0:SIMD_WIDTH-1];

    logic                 s2_valid;
    logic [VW-1:0]        s2_v   [0:SIMD_WIDTH-1];

    logic [HW-1:0]        top_n  [0:SIMD_WIDTH-1];
    logic [HW-1:0]        bot_n  [0:SIMD_WIDTH-1];
    logic [VW-1:0]        v_n    [0:SIMD_WIDTH-1];
    logic [7:0]           pix_n  [0:SIMD_WIDTH-1];

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign busy     = s1_valid | s2_valid | out_valid;

    // Weight (ONE - frac) spans 1..ONE, so frac=0 passes the left/top pixel exactly.
    always_comb begin
        for (int i = 0; i < SIMD_WIDTH; i++) begin
            logic [FRAC_BITS-1:0] fa;
            logic [FRAC_BITS-1:0] fb;
            logic [FRAC_BITS:0]   wa;
            logic [FRAC_BITS:0]   wb;
            logic [VW:0]          sum;
            fa  = a[i][FRAC_BITS-1:0];
            wa  = ONE - (FRAC_BITS+1)'(fa);
            top_n[i] = HW'(p00[i]) * HW'(wa) + HW'(p01[i]) * HW'(fa);
            bot_n[i] = HW'(p10[i]) * HW'(wa) + HW'(p11[i]) * HW'(fa);
            fb  = s1_b[i];
            wb  = ONE - (FRAC_BITS+1)'(fb);
            v_n[i] = VW'(s1_top[i]) * VW'(wb) + VW'(s1_bot[i]) * VW'(fb);
            sum = (VW+1)'(s2_v[i]) + RND;
            pix_n[i] = 8'(sum >> SH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                s1_top[i] <= '0;
                s1_bot[i] <= '0;
                s1_b[i]   <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                s1_top[i] <= top_n[i];
                s1_bot[i] <= bot_n[i];
                s1_b[i]   <= b[i][FRAC_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                s2_v[i] <= '0;
            end
        end else if (adv) begin
            s2_valid <= s1_valid;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                s2_v[i] <= v_n[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                out_pixel[i] <= '0;
            end
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                for (int i = 0; i < SIMD_WIDTH; i++) begin
                    out_pixel[i] <= pix_n[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count <= '0;
        end else if (out_valid && out_ready) begin
            vec_count <= vec_count + 16'd1;
        end
    end

    // A new drop outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/dsa_bilinear_interp_simd.md
Name: dsa_bilinear_interp_simd

Overview:
Downstream compute stage of the SIMD pixel fetcher. It captures one vector of SIMD_WIDTH neighbour quads (p00/p01/p10/p11) and Q0.8 fractions (a, b) on the fetcher's one-cycle valid pulse. It computes the bilinear-interpolated 8-bit output pixel per lane through a 3-stage pipeline. Results go to the writeback stage over a valid/ready handshake, with global pipeline stall and a sticky overflow flag for pulses that arrive while stalled.

Parameters:
SIMD_WIDTH, 4, number of parallel lanes; must match the fetcher.
FRAC_BITS, 8, fraction width used from a/b; a[FRAC_BITS-1:0] and b[FRAC_BITS-1:0] are used, upper bits ignored.

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle pulse, input vector present (driven from fetcher fetch_valid)
in_ready  out  1  pipeline can accept this cycle (upstream uses it to hold off req_valid)
p00/p01/p10/p11  in  8 x [0:SIMD_WIDTH-1]  neighbour pixels per lane
a, b  in  16 x [0:SIMD_WIDTH-1]  horizontal/vertical fractions, Q0.8 in low byte
out_valid  out  1  out_pixel holds a result
out_ready  in  1  consumer accepts when out_valid && out_ready
out_pixel  out  8 x [0:SIMD_WIDTH-1]  interpolated result per lane
vec_count  out  16  number of output vectors accepted since reset, wraps at 65535 -> 0
overflow  out  1  sticky: in_valid arrived while in_ready=0
clr_overflow  in  1  synchronous clear of overflow
busy  out  1  any pipeline stage valid

Behaviour:
- Reset (rst_n=0, async): all stage valids=0, out_valid=0, out_pixel all 0, vec_count=0, overflow=0, busy=0. in_ready=1 after reset.
- Reset mid-operation: in-flight vectors are discarded; there is no partial output.
- Stall: adv = !(out_valid && !out_ready). in_ready = adv (combinational). All stages advance only when adv=1; otherwise every stage register holds.
- S1 (capture + horizontal) on adv:
  - s1_valid <= in_valid.
  - Per lane: top = p00*(256-a8) + p01*a8; bot = p10*(256-a8) + p11*a8. top/bot are 16-bit unsigned; max 65280.
  - Latch b8 alongside.
- S2 (vertical) on adv: s2_valid <= s1_valid; v = top*(256-b8) + bot*b8, 24-bit unsigned, max 16711680.
- S3 (round, output reg) on adv:
  - out_valid <= s2_valid.
  - out_pixel <= (v + 32768) >> 16, truncated to 8 bits. No saturation is needed: the maximum is 255.
  - out_pixel updates only when s2_valid=1 on adv; otherwise the previous value is held.
- Latency: in_valid at cycle N with no stall -> out_valid=1 at N+3. Throughput: 1 vector/cycle.
- out_valid/out_pixel remain stable while out_valid && !out_ready.
- Dropped input: in_valid && !in_ready -> vector discarded and overflow <= 1 on the next edge. If clr_overflow and a new overflow event occur in the same cycle, set wins.
- vec_count increments on each cycle where out_valid && out_ready.
- busy = s1_valid | s2_valid | out_valid.
- Lanes are fully independent; identical arithmetic in every lane. Weight 256-a8 ranges 1..256, so a8=0 passes p00/p10 exactly.
- No FSM beyond the valid pipeline. There are no combinational paths from in_* to out_*.

Test Plan:
1. Reset, then inject p00=10, p01=20, p10=30, p11=40, a=b=128 in all lanes with out_ready=1 -> out_valid exactly 3 cycles later for 1 cycle, out_pixel=25 in every lane, vec_count=1.
2. Lane 0: a=b=0, p00=77; lane 1: a=b=255, p11=200, others 0; lane 2: all p=255, a=37, b=200; lane 3: p01=100, a=255, b=0, others 0 -> out_pixel = {77, 198, 255, 100}.
3. Hold out_ready=0 with a result pending, then pulse in_valid -> in_ready=0, vector dropped, overflow=1. Result held stable. On release, exactly one output is delivered and vec_count +1.
4. Back-to-back in_valid for 3 cycles with distinct vectors, out_ready toggled 1,0,1,... -> 3 results delivered in order, no loss, no duplicates.
5. Assert rst_n=0 for 1 cycle with 2 vectors in flight -> out_valid=0, busy=0, vec_count=0, overflow=0 immediately; no later output appears.
6. Pulse clr_overflow with overflow=1 -> overflow=0 next cycle. Pulse clr_overflow coincident with a dropped in_valid -> overflow stays 1.
